scan_pe_array_pipe: RTL and testbench
=====================================

// Module: scan_pe_array_pipe
// PURPOSE
//  P-lane pipelined LLR processing-element array for the SCAN polar decoder datapath.
//  Successor to the combinational f1-style array: per-transaction mode select (F1/F2/G/ZERO),
//  saturating two's-complement arithmetic, 2-stage pipeline with valid/ready handshake.
//  Sits between the LLR/beta memories and the write-back mux of the SCAN controller.
// PARAMETERS
//  Q      10  LLR/beta word width, signed two's complement
//  P      64  number of lanes
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    input beat valid
//  in_ready   out  1    array can accept beat this cycle
//  in_mode    in   2    op select, sampled with beat: 0=F1 1=F2 2=G 3=ZERO
//  in_enable  in   1    0 -> beat produces all-zero d (legacy bypass), still handshaked
//  a,b,c      in   P*Q  lane i at [(i+1)*Q-1:i*Q]
//  out_valid  out  1    result beat valid
//  out_ready  in   1    consumer accepts result
//  d          out  P*Q  result, lane packing as inputs
// BEHAVIOUR
//  Constants: CEIL=2^(Q-1)-1, FLOR=-2^(Q-1). sat(x): clamp (Q+1)-bit sum to [FLOR,CEIL].
//  minsum(x,y) = sgn(x)*sgn(y)*min(|x|,|y|); |FLOR| taken as CEIL; sgn(0)=+.
//  Per lane: F1 d=minsum(a, sat(b+c)); F2 d=sat(minsum(a,b)+c); G d=sat(a+b) (c ignored);
//   ZERO or in_enable=0 -> d=0.
//  Stage 1 (S1): registers mode/enable-gated s=sat(b+c) or minsum(a,b) and a/c operands.
//  Stage 2 (S2): final op, registers d. Latency exactly 2 cycles input-accept -> out_valid
//   when out_ready stays high; throughput 1 beat/cycle.
//  Handshake: transfer when valid&ready. adv2 = ~s2_valid | out_ready;
//   adv1 = ~s1_valid | adv2; in_ready = adv1 (combinational from out_ready, no other path).
//  Stall: out_valid=1 & out_ready=0 -> d and out_valid hold stable; S1 holds if full;
//   no beat dropped or duplicated; order preserved.
//  Bubble: in_valid=0 while advancing -> stage valid clears; data regs may hold stale.
//  Simultaneous accept+emit each cycle supported (full pipeline never stalls with ready=1).
//  Reset (async assert, sync-released use by caller): s1_valid=0, s2_valid=0, out_valid=0,
//   d=0, in_ready=1 after reset. Reset mid-stream discards in-flight beats.
//  in_mode/in_enable values on non-accepted cycles ignored.
// STRUCTURE
//  Package scan_pe_pkg: mode enum (PE_F1,PE_F2,PE_G,PE_ZERO), sat/abs/minsum functions
//   parameterised by Q, CEIL/FLOR helpers; shared with future g/f array variants.
//  Sub-module scan_pe_lane: one lane, pure combinational S1 and S2 functions
//   (split ports), instantiated P times in a generate loop; pipeline regs and
//   handshake control live in the top.
// TESTING
//  1 Q=10,F1,a=100,b=30,c=-50,enable=1 -> d=-20 two cycles later; a=-5,b=200,c=300 -> d=-5.
//  2 G,a=400,b=300 -> d=511 (CEIL); a=-400,b=-300 -> d=-512; F2 a=-512,b=7,c=-10 -> d=-17.
//  3 ZERO mode, or in_enable=0 with F1 random a/b/c -> d=0 all lanes, out_valid asserted.
//  4 Stream 8 beats, in_valid=1, out_ready=1 -> in_ready stays 1, outputs in order at 1/cycle.
//  5 out_ready=0 for 5 cycles mid-stream -> d stable, in_ready=0 after 2 accepted, no loss.
//  6 Assert rst_n=0 with 2 beats in flight -> out_valid=0,d=0 immediately; after release
//    in_ready=1, next beat emerges alone after 2 cycles; scoreboard vs package model, P=64.

Source files
------------

// File: rtl/scan_pe_pkg.sv
// Shared mode type and saturating two's-complement LLR helpers for the SCAN PE arrays.
// Every helper takes the word width q, so array variants of any width can reuse it.
package scan_pe_pkg;

  typedef enum logic [1:0] {
    PE_F1   = 2'd0,
    PE_F2   = 2'd1,
    PE_G    = 2'd2,
    PE_ZERO = 2'd3
  } pe_mode_e;

  function automatic int pe_ceil(input int q);
    return (1 << (q - 1)) - 1;
  endfunction

  function automatic int pe_flor(input int q);
    return -(1 << (q - 1));
  endfunction

  function automatic int pe_sat(input int x, input int q);
    if (x > pe_ceil(q)) return pe_ceil(q);
    if (x < pe_flor(q)) return pe_flor(q);
    return x;
  endfunction

  // The magnitude of FLOR is not representable in q bits, so it folds onto CEIL.
  function automatic int pe_abs(input int x, input int q);
    if (x == pe_flor(q)) return pe_ceil(q);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int pe_minsum(input int x, input int y, input int q);
    int mx;
    int my;
    int m;
    mx = pe_abs(x, q);
    my = pe_abs(y, q);
    m  = (mx < my) ? mx : my;
    return ((x < 0) != (y < 0)) ? -m : m;
  endfunction

endpackage

// File: rtl/scan_pe_lane.sv
// One PE lane: combinational stage-1 pre-op and stage-2 final op.
// The caller folds in_enable into the mode, so a disabled beat arrives here as PE_ZERO.
module scan_pe_lane
  import scan_pe_pkg::*;
#(
  parameter int Q = 10
) (
  input  logic [1:0]        i_s1_mode,
  input  logic signed [Q-1:0] i_s1_a,
  input  logic signed [Q-1:0] i_s1_b,
  input  logic signed [Q-1:0] i_s1_c,
  output logic signed [Q-1:0] o_s1_s,
  input  logic [1:0]        i_s2_mode,
  input  logic signed [Q-1:0] i_s2_a,
  input  logic signed [Q-1:0] i_s2_s,
  input  logic signed [Q-1:0] i_s2_c,
  output logic signed [Q-1:0] o_s2_d
);

  int w_s;
  int w_d;

  // NOTE: every variable gets a default before the case, so no latch is inferred.
  always_comb begin
    w_s = 0;
    case (pe_mode_e'(i_s1_mode))
      PE_F1:   w_s = pe_sat(int'(i_s1_b) + int'(i_s1_c), Q);
      PE_F2:   w_s = pe_minsum(int'(i_s1_a), int'(i_s1_b), Q);
      PE_G:    w_s = pe_sat(int'(i_s1_a) + int'(i_s1_b), Q);
      default: w_s = 0;
    endcase
  end

  // G finishes in stage 1, so stage 2 only forwards its result.
  always_comb begin
    w_d = 0;
    case (pe_mode_e'(i_s2_mode))
      PE_F1:   w_d = pe_minsum(int'(i_s2_a), int'(i_s2_s), Q);
      PE_F2:   w_d = pe_sat(int'(i_s2_s) + int'(i_s2_c), Q);
      PE_G:    w_d = int'(i_s2_s);
      default: w_d = 0;
    endcase
  end

  assign o_s1_s = Q'(w_s);
  assign o_s2_d = Q'(w_d);

endmodule

// File: rtl/scan_pe_array_pipe.sv
// P-lane, 2-stage pipelined LLR PE array with valid/ready flow control.
// Both stages advance together while the consumer is ready; a full pipe back-pressures in_ready.
module scan_pe_array_pipe
  import scan_pe_pkg::*;
#(
  parameter int Q = 10,
  parameter int P = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_mode,
  input  logic           in_enable,
  input  logic [P*Q-1:0] a,
  input  logic [P*Q-1:0] b,
  input  logic [P*Q-1:0] c,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P*Q-1:0] d
);

  localparam int W = P * Q;

  logic         w_adv1;
  logic         w_adv2;
  pe_mode_e     w_in_mode;
  logic [W-1:0] w_s1_s;
  logic [W-1:0] w_s2_d;

  logic         r_s1_valid;
  logic         r_s2_valid;
  pe_mode_e     r_s1_mode;
  logic [W-1:0] r_s1_s;
  logic [W-1:0] r_s1_a;
  logic [W-1:0] r_s1_c;
  logic [W-1:0] r_d;

  assign w_in_mode = in_enable ? pe_mode_e'(in_mode) : PE_ZERO;
  assign w_adv2    = ~r_s2_valid | out_ready;
  assign w_adv1    = ~r_s1_valid | w_adv2;
  assign in_ready  = w_adv1;
  assign out_valid = r_s2_valid;
  assign d         = r_d;

  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    scan_pe_lane #(.Q(Q)) u_lane (
      .i_s1_mode (w_in_mode),
      .i_s1_a    (a[gi*Q +: Q]),
      .i_s1_b    (b[gi*Q +: Q]),
      .i_s1_c    (c[gi*Q +: Q]),
      .o_s1_s    (w_s1_s[gi*Q +: Q]),
      .i_s2_mode (r_s1_mode),
      .i_s2_a    (r_s1_a[gi*Q +: Q]),
      .i_s2_s    (r_s1_s[gi*Q +: Q]),
      .i_s2_c    (r_s1_c[gi*Q +: Q]),
      .o_s2_d    (w_s2_d[gi*Q +: Q])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_d        <= '0;
    end else begin
      if (w_adv1) r_s1_valid <= in_valid;
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) r_d <= w_s2_d;
      end
    end
  end

  // NOTE: stage-1 payload is never observed without r_s1_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_adv1 && in_valid) begin
      r_s1_mode <= w_in_mode;
      r_s1_s    <= w_s1_s;
      r_s1_a    <= a;
      r_s1_c    <= c;
    end
  end

endmodule

// File: tb/tb_scan_pe_array_pipe.sv
// Directed bench for scan_pe_array_pipe: hand-computed beats, stalls, reset and a lane model scoreboard.
module tb_scan_pe_array_pipe;
  import scan_pe_pkg::*;

  localparam int Q = 10;
  localparam int P = 64;
  localparam int W = P * Q;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_mode = 2'd0;
  logic         in_enable = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] c = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] d;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = 0;
  int last_emit = 0;
  int emit_cnt = 0;
  int emit_cyc[$];
  logic [W-1:0] exp_q[$];
  logic rnd_done = 1'b0;

  scan_pe_array_pipe #(.Q(Q), .P(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_enable (in_enable),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent lane model written directly against Q=10 limits.
  function automatic int m_sat(input int x);
    return (x > 511) ? 511 : ((x < -512) ? -512 : x);
  endfunction

  function automatic int m_mag(input int x);
    return (x == -512) ? 511 : ((x < 0) ? -x : x);
  endfunction

  function automatic int m_ms(input int x, input int y);
    int mx;
    int my;
    int m;
    mx = m_mag(x);
    my = m_mag(y);
    m  = (mx < my) ? mx : my;
    return ((x < 0) != (y < 0)) ? -m : m;
  endfunction

  function automatic logic [W-1:0] model(input logic [1:0] m, input logic en,
                                         input logic [W-1:0] va, input logic [W-1:0] vb,
                                         input logic [W-1:0] vc);
    logic [W-1:0] r;
    int x;
    int y;
    int z;
    int v;
    r = '0;
    for (int i = 0; i < P; i++) begin
      x = int'($signed(va[i*Q +: Q]));
      y = int'($signed(vb[i*Q +: Q]));
      z = int'($signed(vc[i*Q +: Q]));
      if (!en || m == 2'd3) v = 0;
      else if (m == 2'd0)   v = m_ms(x, m_sat(y + z));
      else if (m == 2'd1)   v = m_sat(m_ms(x, y) + z);
      else                  v = m_sat(x + y);
      r[i*Q +: Q] = Q'(v);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rep(input int v);
    logic [W-1:0] r;
    for (int i = 0; i < P; i++) r[i*Q +: Q] = Q'(v);
    return r;
  endfunction

  // Random lanes, with the two extremes pinned into lanes 0 and 1.
  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < P; i++) r[i*Q +: Q] = Q'($urandom);
    r[0 +: Q] = Q'(-512);
    r[Q +: Q] = Q'(511);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", W'(out_valid), W'(0));
      end else begin
        check("d", d, exp_q.pop_front());
        emit_cnt++;
        last_emit = cyc;
        emit_cyc.push_back(cyc);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send(input logic [1:0] m, input logic en, input logic [W-1:0] va,
                      input logic [W-1:0] vb, input logic [W-1:0] vc,
                      input logic [W-1:0] ex, output int waits);
    in_valid = 1'b1; in_mode = m; in_enable = en; a = va; b = vb; c = vc;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", W'(in_ready), W'(1));
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(ex);
      last_acc = cyc;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_mode   = 2'($urandom);
    in_enable = 1'($urandom);
  endtask

  task automatic sendm(input logic [1:0] m, input logic en, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic [W-1:0] vc, output int waits);
    send(m, en, va, vb, vc, model(m, en, va, vb, vc), waits);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (exp_q.size() != 0 && n < 50);
    #1;
    check(tag, W'(exp_q.size()), W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached without finishing", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int e0;
    logic [W-1:0] va, vb, vc, e1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_d", d, '0);
    check("rst_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // F1 hand vectors and single-beat latency
    send(PE_F1, 1'b1, rep(100), rep(30), rep(-50), rep(-20), w);
    drain("t1a_drain");
    check("t1_latency", W'(last_emit - last_acc), W'(2));
    check("t1_bubble", W'(out_valid), W'(0));
    send(PE_F1, 1'b1, rep(-5), rep(200), rep(300), rep(-5), w);
    drain("t1b_drain");

    // G saturation both ways, F2 with FLOR operand
    send(PE_G,  1'b1, rep(400),  rep(300),  rnd(),     rep(511),  w);
    send(PE_G,  1'b1, rep(-400), rep(-300), rnd(),     rep(-512), w);
    send(PE_F2, 1'b1, rep(-512), rep(7),    rep(-10),  rep(-17),  w);
    drain("t2_drain");

    // ZERO mode and disabled beats
    send(PE_ZERO, 1'b1, rnd(), rnd(), rnd(), '0, w);
    send(PE_F1,   1'b0, rnd(), rnd(), rnd(), '0, w);
    drain("t3_drain");

    // 8-beat stream at full rate
    e0 = emit_cyc.size();
    for (int k = 0; k < 8; k++) begin
      va = rnd(); vb = rnd(); vc = rnd();
      sendm(2'(k % 3), 1'b1, va, vb, vc, w);
      check($sformatf("t4_no_wait_%0d", k), W'(w), W'(0));
    end
    drain("t4_drain");
    check("t4_count", W'(emit_cyc.size() - e0), W'(8));
    if (emit_cyc.size() >= e0 + 8)
      check("t4_rate", W'(emit_cyc[e0+7] - emit_cyc[e0]), W'(7));

    // Stall with a full pipe
    out_ready = 1'b0;
    va = rnd(); vb = rnd(); vc = rnd();
    e1 = model(PE_F2, 1'b1, va, vb, vc);
    send(PE_F2, 1'b1, va, vb, vc, e1, w);
    sendm(PE_G, 1'b1, rnd(), rnd(), rnd(), w);
    va = rnd(); vb = rnd(); vc = rnd();
    in_valid = 1'b1; in_mode = PE_F1; in_enable = 1'b1; a = va; b = vb; c = vc;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t5_in_ready_%0d", k), W'(in_ready), W'(0));
      check($sformatf("t5_out_valid_%0d", k), W'(out_valid), W'(1));
      check($sformatf("t5_d_hold_%0d", k), d, e1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    sendm(PE_F1, 1'b1, va, vb, vc, w);
    sendm(PE_F1, 1'b1, rnd(), rnd(), rnd(), w);
    sendm(PE_F2, 1'b1, rnd(), rnd(), rnd(), w);
    drain("t5_drain");

    // Random modes/enables against random back-pressure
    fork
      begin
        for (int k = 0; k < 16; k++)
          sendm(2'($urandom), 1'($urandom_range(0, 3) != 0), rnd(), rnd(), rnd(), w);
        rnd_done = 1'b1;
      end
      begin
        for (int n = 0; n < 500 && !rnd_done; n++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom);
        end
      end
    join
    out_ready = 1'b1;
    drain("rnd_drain");

    // Reset with two beats in flight
    sendm(PE_G, 1'b1, rnd(), rnd(), rnd(), w);
    sendm(PE_F1, 1'b1, rnd(), rnd(), rnd(), w);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", W'(out_valid), W'(0));
    check("t6_rst_d", d, '0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    e0 = emit_cnt;
    sendm(PE_F2, 1'b1, rnd(), rnd(), rnd(), w);
    drain("t6_drain");
    check("t6_latency", W'(last_emit - last_acc), W'(2));
    repeat (4) @(posedge clk);
    #1;
    check("t6_alone", W'(emit_cnt - e0), W'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
